line_drawer: RTL and testbench
==============================

LINE_DRAWER -- requirements
Module: line_drawer

Interface
REQ-001 SHALL have parameter COORD_W, default 10, coordinate width in bits.
REQ-002 SHALL have parameter COLOR_W, default 12, pixel colour width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports x1_in, y1_in  input  COORD_W  line start point, unsigned.
REQ-006 SHALL have ports x2_in, y2_in  input  COORD_W  line end point, unsigned.
REQ-007 SHALL have port color  input  COLOR_W  line colour.
REQ-008 SHALL have port in_rts  input  1  upstream offers a line command.
REQ-009 SHALL have port in_rtr  output  1  block accepts a command (in_rts & in_rtr = accept).
REQ-010 SHALL have port out_rts  output  1  a valid pixel is on x_out/y_out/color_out.
REQ-011 SHALL have port out_rtr  input  1  downstream takes the pixel (out_rts & out_rtr = transfer).
REQ-012 SHALL have ports x_out, y_out  output  COORD_W  current pixel coordinate.
REQ-013 SHALL have port color_out  output  COLOR_W  colour latched with the command.
REQ-014 SHALL have port out_last  output  1  high with the final pixel (x2,y2) of a line.

Function
REQ-015 SHALL implement two states: IDLE (in_rtr=1, out_rts=0) and DRAW (in_rtr=0, out_rts=1).
REQ-016 SHALL, on an accept edge in IDLE, latch all inputs, load x_out=x1, y_out=y1, and enter DRAW; out_rts is high from the next cycle (one-cycle latency).
REQ-017 SHALL ignore in_rts while in DRAW; in_rtr stays low for the whole line.
REQ-018 SHALL use integer Bresenham for all octants: dx=|x2-x1|, dy=-|y2-y1|, sx/sy=+1 or -1 toward the end point, err initialised to dx+dy.
REQ-019 SHALL, on each transfer of a non-final pixel, compute e2=2*err; if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy (both tests use the same pre-update err).
REQ-020 SHALL hold x_out, y_out, color_out and out_last stable while out_rts=1 and out_rtr=0.
REQ-021 SHALL assert out_last when x_out==x2 and y_out==y2; the transfer of that pixel returns the block to IDLE, with in_rtr high on the following cycle.
REQ-022 SHALL emit exactly max(|x2-x1|,|y2-y1|)+1 pixels, first (x1,y1), last (x2,y2), with each step changing x and/or y by at most 1.
REQ-023 SHALL handle x1==x2 and y1==y2 as a single pixel with out_last=1.
REQ-024 SHALL hold err and e2 as signed COORD_W+2 bit values so that no overflow occurs for any coordinate pair.
REQ-025 SHALL allow out_rtr to be held continuously high, giving one pixel per cycle.

Reset
REQ-026 SHALL, while rst_=0 and irrespective of clk, force IDLE, in_rtr=1, out_rts=0, out_last=0, and clear x_out, y_out, color_out and all internal registers to 0.
REQ-027 SHALL, on reset during DRAW, abandon the line with no further pixels emitted; after release the block accepts a new command.

Structure
REQ-028 SHALL place COORD_W, COLOR_W and the state encoding (IDLE, DRAW) in a shared package used by line_drawer and its bench.
REQ-029 SHALL be a single module; no sub-module is required, and |a-b| with its direction sign is inline logic.

Verification
REQ-030 SHALL cover: (4,0)->(0,10), out_rtr=1 -> 11 pixels (4,0),(4,1),(3,2),(3,3),(2,4),(2,5),(2,6),(1,7),(1,8),(0,9),(0,10); out_last only on (0,10); in_rtr low throughout.
REQ-031 SHALL cover: (0,0)->(5,0) -> pixels x=0..5 at y=0, then in_rtr=1 on the cycle after the last transfer.
REQ-032 SHALL cover: (7,7)->(7,7) -> one pixel (7,7) with out_last=1.
REQ-033 SHALL cover: (0,0)->(3,3) with out_rtr toggled 1,0,0,1,... -> pixels (0,0),(1,1),(2,2),(3,3), outputs held stable during every stall.
REQ-034 SHALL cover: (1023,0)->(0,1023) -> 1024 diagonal pixels, no arithmetic overflow.
REQ-035 SHALL cover: rst_ pulsed low mid-line between clock edges -> out_rts=0 and in_rtr=1 immediately; a new command is then accepted and drawn from its start point.

Source files
------------

// File: rtl/line_drawer_pkg.sv
// Shared widths and state encoding for the Bresenham line drawer and its bench.
package line_drawer_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 12;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

endpackage

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: accepts one line command, then streams its pixels
// through a ready/valid (rts/rtr) output until the end point has been taken.
module line_drawer
    import line_drawer_pkg::*;
#(
    parameter int COORD_W = line_drawer_pkg::COORD_W,
    parameter int COLOR_W = line_drawer_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [COORD_W-1:0] x1_in,
    input  logic [COORD_W-1:0] y1_in,
    input  logic [COORD_W-1:0] x2_in,
    input  logic [COORD_W-1:0] y2_in,
    input  logic [COLOR_W-1:0] color,
    input  logic               in_rts,
    output logic               in_rtr,
    output logic               out_rts,
    input  logic               out_rtr,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               out_last
);

    // Two extra bits: one for sign, one so that 2*err never wraps.
    localparam int EW = COORD_W + 2;

    state_t               state;
    logic [COORD_W-1:0]   x2_r;
    logic [COORD_W-1:0]   y2_r;
    logic                 sx_neg;
    logic                 sy_neg;
    logic signed [EW-1:0] dx;
    logic signed [EW-1:0] dy;
    logic signed [EW-1:0] err;

    logic signed [EW-1:0] diff_x;
    logic signed [EW-1:0] diff_y;
    logic signed [EW-1:0] abs_x;
    logic signed [EW-1:0] abs_y;
    logic signed [EW-1:0] e2;
    logic signed [EW-1:0] err_next;
    logic                 step_x;
    logic                 step_y;
    logic [COORD_W-1:0]   nx;
    logic [COORD_W-1:0]   ny;

    assign in_rtr  = (state == IDLE);
    assign out_rts = (state == DRAW);

    always_comb begin
        diff_x   = $signed({2'b00, x2_in}) - $signed({2'b00, x1_in});
        diff_y   = $signed({2'b00, y2_in}) - $signed({2'b00, y1_in});
        abs_x    = (diff_x < 0) ? -diff_x : diff_x;
        abs_y    = (diff_y < 0) ? -diff_y : diff_y;
        e2       = err <<< 1;
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        err_next = err;
        nx       = x_out;
        ny       = y_out;
        if (step_x) begin
            err_next = err_next + dy;
            nx       = sx_neg ? x_out - 1'b1 : x_out + 1'b1;
        end
        if (step_y) begin
            err_next = err_next + dx;
            ny       = sy_neg ? y_out - 1'b1 : y_out + 1'b1;
        end
    end

    // out_last is precomputed from the next coordinate so it is valid the
    // same cycle that pixel appears on the output.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
            out_last  <= 1'b0;
            x2_r      <= '0;
            y2_r      <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_rts) begin
                        x_out     <= x1_in;
                        y_out     <= y1_in;
                        color_out <= color;
                        x2_r      <= x2_in;
                        y2_r      <= y2_in;
                        sx_neg    <= (diff_x < 0);
                        sy_neg    <= (diff_y < 0);
                        dx        <= abs_x;
                        dy        <= -abs_y;
                        err       <= abs_x - abs_y;
                        out_last  <= (x1_in == x2_in) && (y1_in == y2_in);
                        state     <= DRAW;
                    end
                end
                DRAW: begin
                    if (out_rtr) begin
                        if (out_last) begin
                            out_last <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            x_out    <= nx;
                            y_out    <= ny;
                            err      <= err_next;
                            out_last <= (nx == x2_r) && (ny == y2_r);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Scoreboard bench for line_drawer: directed line commands push hand-derived
// pixel lists; a monitor compares every presented pixel against the queue head.
module tb_line_drawer;
    import line_drawer_pkg::*;

    typedef struct {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               last;
        logic [COLOR_W-1:0] col;
    } pix_t;

    logic               clk;
    logic               rst_;
    logic [COORD_W-1:0] x1_in, y1_in, x2_in, y2_in;
    logic [COLOR_W-1:0] color;
    logic               in_rts;
    logic               in_rtr;
    logic               out_rts;
    logic               out_rtr;
    logic [COORD_W-1:0] x_out, y_out;
    logic [COLOR_W-1:0] color_out;
    logic               out_last;

    pix_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   rtr_mode = 0;
    int   rtr_phase = 0;

    line_drawer #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) dut (
        .clk(clk), .rst_(rst_),
        .x1_in(x1_in), .y1_in(y1_in), .x2_in(x2_in), .y2_in(y2_in),
        .color(color), .in_rts(in_rts), .in_rtr(in_rtr),
        .out_rts(out_rts), .out_rtr(out_rtr),
        .x_out(x_out), .y_out(y_out), .color_out(color_out), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_px(input int x, input int y, input logic last, input int col);
        pix_t p;
        p.x    = COORD_W'(x);
        p.y    = COORD_W'(y);
        p.last = last;
        p.col  = COLOR_W'(col);
        sb.push_back(p);
    endtask

    // Issue one command at posedge+1; optionally keep in_rts high with junk
    // coordinates afterwards to show the block ignores it while drawing.
    task automatic applyStimulus(input int ax, input int ay, input int bx, input int by,
                                 input int col, input bit keep);
        x1_in  = COORD_W'(ax);
        y1_in  = COORD_W'(ay);
        x2_in  = COORD_W'(bx);
        y2_in  = COORD_W'(by);
        color  = COLOR_W'(col);
        in_rts = 1'b1;
        checkOutput("in_rtr_before_accept", 32'(in_rtr), 32'd1);
        @(posedge clk);
        #1;
        if (keep) begin
            x1_in = COORD_W'(100);
            y1_in = COORD_W'(200);
            x2_in = COORD_W'(300);
            y2_in = COORD_W'(400);
        end else begin
            in_rts = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_rts = 1'b0;
        if (sb.size() != 0) begin
            checkOutput({name, "_timeout_pending"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        checkOutput({name, "_in_rtr_after"}, 32'(in_rtr), 32'd1);
        checkOutput({name, "_out_rts_after"}, 32'(out_rts), 32'd0);
    endtask

    // out_rtr pattern: mode 0 always ready, mode 1 repeating 1,0,0.
    initial begin
        out_rtr = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rtr_mode == 1) begin
                rtr_phase++;
                out_rtr = (rtr_phase % 3 == 0);
            end else begin
                out_rtr = 1'b1;
            end
        end
    end

    // Monitor: compare every presented pixel, pop only on transfer, so a stall
    // re-checks the same expected pixel and catches any output drift.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (rst_ && out_rts) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("[TB] FAIL unexpected_pixel: got (%0d,%0d), expected none", x_out, y_out);
                end else begin
                    e = sb[0];
                    checkOutput("x_out", 32'(x_out), 32'(e.x));
                    checkOutput("y_out", 32'(y_out), 32'(e.y));
                    checkOutput("out_last", 32'(out_last), 32'(e.last));
                    checkOutput("color_out", 32'(color_out), 32'(e.col));
                    checkOutput("in_rtr_during_draw", 32'(in_rtr), 32'd0);
                    if (out_rtr) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_   = 1'b0;
        in_rts = 1'b0;
        x1_in  = '0; y1_in = '0; x2_in = '0; y2_in = '0;
        color  = '0;
        #2;
        checkOutput("rst_in_rtr", 32'(in_rtr), 32'd1);
        checkOutput("rst_out_rts", 32'(out_rts), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_x_out", 32'(x_out), 32'd0);
        checkOutput("rst_y_out", 32'(y_out), 32'd0);
        checkOutput("rst_color_out", 32'(color_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;
        @(posedge clk);
        #1;

        // Steep line going left, in_rts held high throughout.
        push_px(4, 0, 0, 12'hABC); push_px(4, 1, 0, 12'hABC);
        push_px(3, 2, 0, 12'hABC); push_px(3, 3, 0, 12'hABC);
        push_px(2, 4, 0, 12'hABC); push_px(2, 5, 0, 12'hABC);
        push_px(2, 6, 0, 12'hABC); push_px(1, 7, 0, 12'hABC);
        push_px(1, 8, 0, 12'hABC); push_px(0, 9, 0, 12'hABC);
        push_px(0, 10, 1, 12'hABC);
        applyStimulus(4, 0, 0, 10, 12'hABC, 1'b1);
        wait_done("steep", 100);

        // Horizontal line.
        for (int i = 0; i <= 5; i++) push_px(i, 0, (i == 5), 12'h123);
        applyStimulus(0, 0, 5, 0, 12'h123, 1'b0);
        wait_done("horiz", 100);

        // Single point.
        push_px(7, 7, 1, 12'hF0F);
        applyStimulus(7, 7, 7, 7, 12'hF0F, 1'b0);
        wait_done("point", 20);

        // Diagonal with downstream stalls.
        rtr_mode  = 1;
        rtr_phase = 0;
        for (int i = 0; i <= 3; i++) push_px(i, i, (i == 3), 12'h055);
        applyStimulus(0, 0, 3, 3, 12'h055, 1'b0);
        wait_done("stall", 100);
        rtr_mode = 0;
        @(posedge clk);
        #1;

        // Full-range anti-diagonal.
        for (int i = 0; i <= 1023; i++) push_px(1023 - i, i, (i == 1023), 12'hFFF);
        applyStimulus(1023, 0, 0, 1023, 12'hFFF, 1'b0);
        wait_done("antidiag", 1200);

        // Reset in the middle of a line, between clock edges.
        for (int i = 0; i <= 9; i++) push_px(i, 0, (i == 9), 12'h321);
        applyStimulus(0, 0, 9, 0, 12'h321, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_ = 1'b0;
        #1;
        checkOutput("midrst_out_rts", 32'(out_rts), 32'd0);
        checkOutput("midrst_in_rtr", 32'(in_rtr), 32'd1);
        checkOutput("midrst_x_out", 32'(x_out), 32'd0);
        checkOutput("midrst_out_last", 32'(out_last), 32'd0);
        sb.delete();
        @(posedge clk);
        #2 rst_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("postrst_out_rts", 32'(out_rts), 32'd0);
        push_px(2, 3, 0, 12'h777); push_px(3, 4, 0, 12'h777); push_px(4, 4, 1, 12'h777);
        applyStimulus(2, 3, 4, 4, 12'h777, 1'b0);
        wait_done("postrst", 50);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
